// File: rtl/configs_loader.sv
// configs_loader: streams NUM_WORDS configuration words into an external
// latch array. Each word is accepted on a valid/ready handshake, placed on
// io_d_out, and latched by a single registered one-hot enable pulse that is
// framed by one setup cycle before and one hold cycle after it.
//
// Optional feature macro: CONFIGS_LOADER_CHECKSUM_EN
//   defined   -> words are XOR-accumulated and one trailing checksum word is
//                accepted in CHECK; a mismatch sets the sticky io_err flag.
//   undefined -> no CHECK state, no accumulator, io_err tied low.

module configs_loader #(
    parameter int NUM_WORDS = 46,
    parameter int WORD_W    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 io_start,
    input  logic [WORD_W-1:0]    io_word_in,
    input  logic                 io_word_valid,
    output logic                 io_word_ready,
    output logic [WORD_W-1:0]    io_d_out,
    output logic [NUM_WORDS-1:0] io_configs_en,
    output logic                 io_busy,
    output logic                 io_done,
    output logic                 io_err
);

    localparam int               IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_SETUP  = 3'd2;
    localparam logic [2:0] S_STROBE = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;
`ifdef CONFIGS_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHECK  = 3'd5;
`endif
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [WORD_W-1:0]    d_out_q, d_out_d;
    logic [NUM_WORDS-1:0] en_q, en_d;
    logic                 accept;

    // Ready is a pure state decode so reset drops it immediately.
`ifdef CONFIGS_LOADER_CHECKSUM_EN
    assign io_word_ready = (state_q == S_WAIT) || (state_q == S_CHECK);
`else
    assign io_word_ready = (state_q == S_WAIT);
`endif

    assign accept        = io_word_valid & io_word_ready;
    assign io_busy       = (state_q != S_IDLE);
    assign io_done       = (state_q == S_DONE);
    assign io_d_out      = d_out_q;
    assign io_configs_en = en_q;

    // Next-state logic for the load sequencer, data register and strobe.
    always_comb begin
        // NOTE: every variable gets a default here so no path leaves it
        // unassigned; otherwise synthesis would infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        d_out_d = d_out_q;
        en_d    = '0;

        case (state_q)
            S_IDLE: begin
                if (io_start) begin
                    idx_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (accept) begin
                    d_out_d = io_word_in;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                // Enable is registered, so it goes high exactly in STROBE.
                en_d[idx_q] = 1'b1;
                state_d     = S_STROBE;
            end
            S_STROBE: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (idx_q == LAST_IDX) begin
`ifdef CONFIGS_LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_WAIT;
                end
            end
`ifdef CONFIGS_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept) begin
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state registers; reset abandons any partial load at once.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments keep every register updating from
        // the pre-edge values, matching real flip-flop behaviour.
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            d_out_q <= '0;
            en_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            d_out_q <= d_out_d;
            en_q    <= en_d;
        end
    end

`ifdef CONFIGS_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] acc_q;
    logic              err_q;

    // XOR accumulator over accepted data words and sticky checksum error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            err_q <= 1'b0;
        end else if ((state_q == S_IDLE) && io_start) begin
            acc_q <= '0;
            err_q <= 1'b0;
        end else if ((state_q == S_WAIT) && accept) begin
            acc_q <= acc_q ^ io_word_in;
        end else if ((state_q == S_CHECK) && accept && (io_word_in != acc_q)) begin
            err_q <= 1'b1;
        end
    end

    assign io_err = err_q;
`else
    assign io_err = 1'b0;
`endif

endmodule

// File: tb/tb_configs_loader.sv
// Randomized self-checking bench for configs_loader. A transaction-level
// model (list of words sent, expected strobe order, done count, error flag)
// is compared against strobes and handshakes observed on the DUT pins.

module tb_configs_loader;

    localparam int NW = 46;
    localparam int WW = 32;

    logic          clk;
    logic          reset;
    logic          io_start;
    logic [WW-1:0] io_word_in;
    logic          io_word_valid;
    logic          io_word_ready;
    logic [WW-1:0] io_d_out;
    logic [NW-1:0] io_configs_en;
    logic          io_busy;
    logic          io_done;
    logic          io_err;

    configs_loader #(
        .NUM_WORDS (NW),
        .WORD_W    (WW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .io_start      (io_start),
        .io_word_in    (io_word_in),
        .io_word_valid (io_word_valid),
        .io_word_ready (io_word_ready),
        .io_d_out      (io_d_out),
        .io_configs_en (io_configs_en),
        .io_busy       (io_busy),
        .io_done       (io_done),
        .io_err        (io_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Monitor bookkeeping (negedge samples).
    int            cyc = 0;
    int            acc_cnt;
    int            first_acc;
    int            done_cnt;
    int            done_cyc;
    bit            done_seen;
    bit            after_strobe = 1'b0;
    logic [WW-1:0] strobe_dout;
    logic [WW-1:0] prev_dout = '0;
    int            got_idx[$];
    logic [WW-1:0] got_dat[$];

    // Reference model: the words of the current sequence.
    logic [WW-1:0] words [NW];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        acc_cnt   = 0;
        first_acc = 0;
        done_cnt  = 0;
        done_cyc  = 0;
        done_seen = 1'b0;
        got_idx.delete();
        got_dat.delete();
    endtask

    // Pin monitor: records strobes and completion, checks hold margin.
    always @(negedge clk) begin
        int hot;
        cyc++;
        if (reset) begin
            after_strobe = 1'b0;
        end else begin
            if (io_word_valid && io_word_ready) begin
                if (acc_cnt == 0) first_acc = cyc;
                acc_cnt++;
            end
            if (after_strobe) begin
                check("hold_en_low", io_configs_en, '0);
                check("hold_dout", io_d_out, strobe_dout);
            end
            if (io_configs_en != '0) begin
                hot = 0;
                for (int b = 0; b < NW; b++) if (io_configs_en[b]) hot = b;
                check("en_onehot", $countones(io_configs_en), 1);
                check("setup_dout", io_d_out, prev_dout);
                check("strobe_busy", io_busy, 1'b1);
                got_idx.push_back(hot);
                got_dat.push_back(io_d_out);
                strobe_dout  = io_d_out;
                after_strobe = 1'b1;
            end else begin
                after_strobe = 1'b0;
            end
            if (io_done) begin
                done_cnt++;
                done_cyc  = cyc;
                done_seen = 1'b1;
            end
        end
        prev_dout = io_d_out;
    end

    task automatic start_seq();
        io_start = 1'b1;
        tick();
        io_start = 1'b0;
    endtask

    task automatic send_word(input logic [WW-1:0] w, input int gap, input bit poke_start);
        int n;
        io_word_valid = 1'b0;
        repeat (gap) tick();
        if (gap >= 5) begin
            check("stall_ready", io_word_ready, 1'b1);
            check("stall_en", io_configs_en, '0);
            check("stall_busy", io_busy, 1'b1);
        end
        io_word_in    = w;
        io_word_valid = 1'b1;
        io_start      = poke_start;
        n = 0;
        while (!io_word_ready && n < 64) begin
            tick();
            io_start = 1'b0;
            n++;
        end
        check("ready_timeout", n < 64, 1'b1);
        tick();
        io_word_valid = 1'b0;
        io_start      = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done_seen && n < 400) begin
            tick();
            n++;
        end
        check("done_timeout", n < 400, 1'b1);
    endtask

    // mode 0: words 1..NW back to back; 1: random words/gaps, word 3 stalled
    // 10 cycles; 2: random, io_start poked at word 10; 3: all 0xA5A5A5A5.
    task automatic run_seq(input int mode, input bit bad_ck);
        logic [WW-1:0] ck;
        int            gap;
        bit            exp_err;
        clear_mon();
        ck = '0;
        for (int i = 0; i < NW; i++) begin
            case (mode)
                0:       words[i] = WW'(i + 1);
                3:       words[i] = 32'hA5A5A5A5;
                default: words[i] = $urandom();
            endcase
            ck ^= words[i];
        end
        start_seq();
        check("err_clear_on_start", io_err, 1'b0);
        check("busy_after_start", io_busy, 1'b1);
        for (int i = 0; i < NW; i++) begin
            if (mode == 0 || mode == 3) gap = 0;
            else if (mode == 1 && i == 3) gap = 10;
            else gap = $urandom_range(0, 3);
            send_word(words[i], gap, (mode == 2) && (i == 10));
        end
`ifdef CONFIGS_LOADER_CHECKSUM_EN
        send_word(ck ^ WW'(bad_ck), $urandom_range(0, 2), 1'b0);
        exp_err = bad_ck;
`else
        exp_err = 1'b0;
`endif
        wait_done();
        check("n_strobes", got_idx.size(), NW);
        for (int i = 0; i < NW && i < got_idx.size(); i++) begin
            check("strobe_idx", got_idx[i], i);
            check("strobe_data", got_dat[i], words[i]);
        end
        check("done_count", done_cnt, 1);
        check("err_flag", io_err, exp_err);
        check("idle_busy", io_busy, 1'b0);
        check("idle_done", io_done, 1'b0);
`ifndef CONFIGS_LOADER_CHECKSUM_EN
        if (mode == 0) check("done_latency", done_cyc - first_acc, 184);
`endif
    endtask

    task automatic abort_test();
        int n;
        clear_mon();
        start_seq();
        for (int i = 0; i < 6; i++) send_word($urandom(), 0, 1'b0);
        n = 0;
        while (!io_configs_en[5] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("abort_strobe5_seen", n < 20, 1'b1);
        reset = 1'b1;
        #1;
        check("abort_en", io_configs_en, '0);
        check("abort_busy", io_busy, 1'b0);
        check("abort_ready", io_word_ready, 1'b0);
        check("abort_dout", io_d_out, '0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        tick();
        repeat (3) tick();
        check("abort_no_resume_busy", io_busy, 1'b0);
        check("abort_no_resume_en", io_configs_en, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        io_start      = 1'b0;
        io_word_in    = '0;
        io_word_valid = 1'b0;
        #1;
        check("rst_en", io_configs_en, '0);
        check("rst_dout", io_d_out, '0);
        check("rst_busy", io_busy, 1'b0);
        check("rst_done", io_done, 1'b0);
        check("rst_ready", io_word_ready, 1'b0);
        check("rst_err", io_err, 1'b0);
        #20;
        reset = 1'b0;
        tick();
        check("idle_after_rst", io_busy, 1'b0);

        run_seq(0, 1'b0);
        run_seq(1, 1'b0);
        abort_test();
        run_seq(1, 1'b0);
        run_seq(2, 1'b0);
        run_seq(2, 1'b0);
        run_seq(3, 1'b0);
`ifdef CONFIGS_LOADER_CHECKSUM_EN
        run_seq(3, 1'b1);
`endif
        run_seq(1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/configs_loader.md
CONFIGS_LOADER -- requirements
Module: configs_loader

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 46, giving the number of configuration words and the io_configs_en width.
REQ-002 SHALL have parameter WORD_W, default 32, giving the configuration word width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port io_start, input, 1 bit: begins a load sequence when the block is idle.
REQ-006 SHALL have port io_word_in, input, WORD_W bits: the incoming configuration word.
REQ-007 SHALL have port io_word_valid, input, 1 bit: io_word_in is valid.
REQ-008 SHALL have port io_word_ready, output, 1 bit: the block will accept a word this cycle.
REQ-009 SHALL have port io_d_out, output, WORD_W bits: data bus to the latch array.
REQ-010 SHALL have port io_configs_en, output, NUM_WORDS bits: one-hot latch enables.
REQ-011 SHALL have port io_busy, output, 1 bit: high while a sequence is in progress.
REQ-012 SHALL have port io_done, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have port io_err, output, 1 bit: sticky checksum error flag.

Function
REQ-014 SHALL use FSM states IDLE, WAIT, SETUP, STROBE, HOLD, CHECK and DONE, together with a word index idx of width ceil(log2(NUM_WORDS)).
REQ-015 SHALL, in IDLE with io_start=1, clear idx to 0 and go to WAIT; io_start SHALL be ignored in all other states.
REQ-016 SHALL assert io_word_ready only in WAIT and CHECK; a word transfers on any cycle where io_word_valid & io_word_ready.
REQ-017 SHALL, on a WAIT transfer, register the word into io_d_out and go to SETUP, with io_configs_en all zero.
REQ-018 SHALL go from SETUP to STROBE, and in STROBE drive io_configs_en[idx]=1 and all other enable bits to 0 for exactly one cycle.
REQ-019 SHALL go from STROBE to HOLD with io_configs_en all zero and io_d_out unchanged.
REQ-020 SHALL, from HOLD with idx<NUM_WORDS-1, increment idx and go to WAIT; with idx==NUM_WORDS-1 it SHALL go to CHECK (macro defined) or DONE (macro undefined).
REQ-021 SHALL hold io_d_out stable from SETUP through HOLD, giving setup and hold margin around the latch strobe.
REQ-022 SHALL drive io_configs_en from a register (glitch-free), never more than one bit high, and high only in STROBE.
REQ-023 SHALL take a minimum of 4 cycles per word, counting from the WAIT acceptance cycle to the cycle after HOLD.
REQ-024 SHALL, when io_word_valid is low in WAIT, stall in WAIT indefinitely with no timeout.
REQ-025 SHALL assert io_busy in every state except IDLE.
REQ-026 SHALL assert io_done in DONE for one cycle, then return to IDLE.
REQ-027 SHALL allow a new io_start in the cycle after DONE to begin a new sequence; the latch contents are simply overwritten.

Reset
REQ-028 SHALL, on reset assertion, immediately force state IDLE, idx=0, io_d_out=0, io_configs_en=0, io_word_ready=0, io_busy=0, io_done=0 and io_err=0, independent of clk.
REQ-029 SHALL, on reset asserted mid-sequence including during STROBE, drop the enable at once; a partial load SHALL be abandoned and not resumed.

Configuration
REQ-030 SHALL, with CONFIGS_LOADER_CHECKSUM_EN defined, XOR-accumulate every accepted data word and accept one extra checksum word in CHECK.
REQ-031 SHALL, with CONFIGS_LOADER_CHECKSUM_EN defined, set io_err to 1 if the checksum word differs from the accumulator and hold it until the next io_start or reset; DONE SHALL follow regardless.
REQ-032 SHALL, with CONFIGS_LOADER_CHECKSUM_EN undefined, omit the CHECK state and accumulator entirely and tie io_err to 0.

Verification
REQ-033 SHALL verify: reset, start, then 46 back-to-back valid words 0x00000001..0x0000002E -> each io_configs_en[i] pulses exactly once with io_d_out=i+1, and io_done pulses 184 cycles after the first acceptance (macro undefined).
REQ-034 SHALL verify: word 3 delivered with io_word_valid low for 10 cycles -> FSM stays in WAIT, io_configs_en=0 throughout, and the sequence completes normally.
REQ-035 SHALL verify: reset asserted while state=STROBE for idx=5 -> io_configs_en=0 in the same cycle and io_busy=0; a subsequent start reloads from idx=0.
REQ-036 SHALL verify: io_start pulsed while busy at idx=10 -> no effect on idx or the data sequence.
REQ-037 SHALL verify (macro defined): 46 words of 0xA5A5A5A5 plus checksum 0x00000000 -> io_err=0; same words plus checksum 0x00000001 -> io_err=1, io_done pulses, and io_err clears on the next io_start.
